// File: rtl/feeder_pkg.sv
// feeder_pkg: shared definitions for the operand_feeder edge streamer.
//   - DEF_DATA_WIDTH / DEF_DEPTH : default operand width and buffer depth
//   - IDLE..DONE                 : FSM state encoding (3 bits)
//   - state_t                    : enum over that encoding, used by the FSM
package feeder_pkg;

  localparam int DEF_DATA_WIDTH = 32;
  localparam int DEF_DEPTH      = 8;

  localparam logic [2:0] IDLE = 3'd0;
  localparam logic [2:0] SEND = 3'd1;
  localparam logic [2:0] HOLD = 3'd2;
  localparam logic [2:0] FIN  = 3'd3;
  localparam logic [2:0] DONE = 3'd4;

  typedef enum logic [2:0] {
    ST_IDLE = IDLE,
    ST_SEND = SEND,
    ST_HOLD = HOLD,
    ST_FIN  = FIN,
    ST_DONE = DONE
  } state_t;

endpackage

// File: rtl/feeder_buf.sv
// feeder_buf: DEPTH x DATA_WIDTH register-file operand buffer.
//   clk   : write clock (rising edge)
//   we    : write enable
//   waddr : write address
//   wdata : write data
//   raddr : asynchronous read address
//   rdata : asynchronous read data (mem[raddr])
// Contents are not reset; readers gate rdata with their own valid state.
module feeder_buf #(
  parameter int DATA_WIDTH = 32,
  parameter int DEPTH      = 8,
  parameter int AW         = 3
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [AW-1:0]         waddr,
  input  logic [DATA_WIDTH-1:0] wdata,
  input  logic [AW-1:0]         raddr,
  output logic [DATA_WIDTH-1:0] rdata
);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/operand_feeder.sv
// operand_feeder: buffers up to DEPTH operands and streams them one at a time
// to a MAC PE input port, then raises an end-of-stream marker.
//
// Optional feature macro: FEEDER_REPLAY_EN
//   defined   : DONE keeps count/buffer so a later start replays the operands;
//               extra input clr (sampled in IDLE only) empties the buffer.
//   undefined : DONE empties the buffer; no clr port.
//
// Ports:
//   clk, rst        : clock, synchronous active-high reset
//   ld_valid/ld_data/ld_ready : load port, accepted when ld_valid && ld_ready
//   start           : single-cycle stream request (honoured in IDLE only)
//   busy            : stream in progress (state != IDLE)
//   done            : one-cycle pulse when a stream completes
//   out_data        : operand offered to the PE (0 when not streaming)
//   out_waiting     : out_data is offered this cycle
//   out_finished    : end-of-stream marker
//   out_ready       : PE ready to accept
//   clr             : (FEEDER_REPLAY_EN only) clear buffered operands
//   dbg_state       : current FSM state
//
// Handshake: an operand transfers in a cycle with out_waiting && out_ready,
// after which the PE gets one HOLD cycle (waiting low, data still stable) to
// accumulate. End-of-stream completes in a cycle with out_finished &&
// out_ready. Every output decodes registered state only, so out_ready never
// reaches an output combinationally.
module operand_feeder
  import feeder_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  ld_valid,
  input  logic [DATA_WIDTH-1:0] ld_data,
  output logic                  ld_ready,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_waiting,
  output logic                  out_finished,
  input  logic                  out_ready,
`ifdef FEEDER_REPLAY_EN
  input  logic                  clr,
`endif
  output logic [2:0]            dbg_state
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  state_t                state_q, state_d;
  logic [CW-1:0]         count_q, count_d;
  logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         base_count;
  logic                  load;
  logic [DATA_WIDTH-1:0] rdata;

  feeder_buf #(
    .DATA_WIDTH (DATA_WIDTH),
    .DEPTH      (DEPTH),
    .AW         (AW)
  ) u_buf (
    .clk   (clk),
    .we    (load),
    .waddr (base_count[AW-1:0]),
    .wdata (ld_data),
    .raddr (rd_ptr_q),
    .rdata (rdata)
  );

  assign ld_ready     = (state_q == ST_IDLE) && (count_q < DEPTH_C);
  assign load         = ld_valid && ld_ready;
  assign busy         = (state_q != ST_IDLE);
  assign done         = (state_q == ST_DONE);
  assign out_waiting  = (state_q == ST_SEND);
  assign out_finished = (state_q == ST_FIN);
  assign out_data     = ((state_q == ST_SEND) || (state_q == ST_HOLD)) ? rdata : '0;
  assign dbg_state    = state_q;

  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    base_count = count_q;
`ifdef FEEDER_REPLAY_EN
    // clr empties the buffer first so a same-cycle load lands in entry 0.
    if ((state_q == ST_IDLE) && clr) begin
      base_count = '0;
    end
`endif
    count_d = load ? (base_count + CW'(1)) : base_count;

    case (state_q)
      ST_IDLE: begin
        // count_d already includes a same-cycle load, so that entry streams too.
        if (start) begin
          if (count_d != '0) begin
            state_d  = ST_SEND;
            rd_ptr_d = '0;
          end else begin
            state_d = ST_FIN;
          end
        end
      end
      ST_SEND: begin
        if (out_ready) begin
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (CW'(rd_ptr_q) == (count_q - CW'(1))) begin
          state_d = ST_FIN;
        end else begin
          rd_ptr_d = rd_ptr_q + AW'(1);
          state_d  = ST_SEND;
        end
      end
      ST_FIN: begin
        if (out_ready) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
`ifndef FEEDER_REPLAY_EN
        count_d = '0;
`endif
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      count_q  <= '0;
      rd_ptr_q <= '0;
    end else begin
      state_q  <= state_d;
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

endmodule

// File: doc/operand_feeder.md
# operand_feeder

Edge streamer for the systolic array. Buffers up to DEPTH operands and presents them one at a time to a MAC processing element's A or B input port using the waiting/ready/finished handshake. After the last element it signals end-of-stream so the PE publishes its accumulated result. One operand_feeder instance sits on each row (A side) and each column (B side) of the array.

## Interface
- DATA_WIDTH, 32, operand width in bits
- DEPTH, 8, buffer entries (maximum stream length); must be ≥1
- clk  input  1  clock; all state updates on its rising edge
- rst  input  1  synchronous, active-high reset
- ld_valid  input  1  load request for the next buffer entry
- ld_data  input  DATA_WIDTH  operand to load
- ld_ready  output  1  buffer can accept a load this cycle
- start  input  1  single-cycle request to stream the buffered operands
- busy  output  1  a stream is in progress
- done  output  1  one-cycle pulse when a stream completes
- out_data  output  DATA_WIDTH  operand presented to the PE
- out_waiting  output  1  out_data is valid and offered to the PE
- out_finished  output  1  end-of-stream marker
- out_ready  input  1  PE is ready to accept (PE IN_WAIT state)

## Operation
- Buffer: DEPTH×DATA_WIDTH register array, with count (width $clog2(DEPTH+1)) and rd_ptr (width $clog2(DEPTH)).
- Load: accepted when ld_valid && ld_ready. Data goes to buf[count], and count increments. ld_ready = (state==IDLE) && (count<DEPTH). Loads during a stream are refused.
- States: IDLE, SEND, HOLD, FIN, DONE.
- IDLE: outputs idle.
  - start && count>0 → SEND, rd_ptr=0.
  - start && count==0 → FIN. This sends an empty stream.
- SEND: out_waiting=1, out_data=buf[rd_ptr].
  - out_ready=1 → HOLD. This cycle is the transfer.
  - Otherwise stay in SEND; out_data stays stable.
- HOLD: out_waiting=0 and out_data still equals buf[rd_ptr]. The PE accumulates the operand in this cycle. Stay in HOLD for exactly one cycle.
  - If rd_ptr==count-1 → FIN.
  - Otherwise rd_ptr++ → SEND.
- FIN: out_finished=1, out_waiting=0.
  - out_ready=1 → DONE.
  - Otherwise stay in FIN.
- DONE: done=1 for one cycle, then → IDLE. count is cleared unless replay is enabled (see Configuration).
- busy = (state != IDLE).
- start outside IDLE is ignored.
- ld_valid and start in the same IDLE cycle: the load is accepted, then the stream starts using the updated count. The new entry is included.
- Reset (at any time, including mid-stream):
  - state=IDLE, count=0, rd_ptr=0.
  - out_data=0, out_waiting=0, out_finished=0, done=0, busy=0.
  - ld_ready=1 in the first cycle after reset.
  - Buffer contents are don't-care.
- All outputs are registered or decoded from registered state only. There is no combinational path from out_ready to any output.

## Timing
- start sampled at edge t → out_waiting=1 from cycle t+1.
- Each element takes at least 2 cycles: SEND then HOLD. Each extra cycle with out_ready=0 adds 1 cycle.
- N elements with out_ready held high: first waiting at t+1, out_finished at t+1+2N, done at t+2+2N, IDLE at t+3+2N.
- out_data changes only on the SEND entry edge. It is stable across the SEND and HOLD pair.

## Configuration
- FEEDER_REPLAY_EN defined: DONE leaves count and the buffer intact. A later start re-streams the same operands without reloading. ld_ready stays 0 while count==DEPTH. An added input clr (1 bit, sampled only in IDLE) sets count=0.
- FEEDER_REPLAY_EN undefined: DONE clears count to 0, and the buffer must be reloaded before each stream. The clr port does not exist.

## Structure
- Package feeder_pkg:
  - state encoding localparams: IDLE=3'd0, SEND=3'd1, HOLD=3'd2, FIN=3'd3, DONE=3'd4
  - default DATA_WIDTH and DEPTH
- Sub-module feeder_buf: register-file buffer with write port (we, waddr, wdata) and asynchronous read port (raddr, rdata). The FSM and counters live in operand_feeder.

## Test plan
- Reset mid-stream: rst during SEND of element 2 → next cycle out_waiting=0, out_finished=0, busy=0, ld_ready=1, count=0.
- Load 3 values (5, 7, 9), then start with out_ready=1 → out_data 5, 7, 9 each shown for 2 cycles with waiting high in the first; out_finished at start+7; done at start+8.
- Backpressure: out_ready=0 for 4 cycles in SEND of element 1 → out_waiting and out_data stay stable. Transfer happens on the first cycle with out_ready=1, with no element skipped or duplicated.
- Full buffer: load DEPTH=8 values → ld_ready=0 after the 8th; a 9th ld_valid is dropped. Stream emits exactly 8 elements.
- Empty stream: start with count=0 → out_finished the next cycle, done one cycle after out_ready, with no out_waiting.
- Replay (FEEDER_REPLAY_EN): after streaming 2, 4, a second start without loads → 2, 4 again. Without the macro, the second start produces an empty stream.
